// File: rtl/vga_switch_pkg.sv
// Shared types and helpers for the frame-synchronous VGA source switch.
package vga_switch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    BLACK   = 2'd2
  } sw_state_e;

  // Select width: max(1, clog2(n))
  function automatic int sel_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // LSB of source idx inside a packed N_SRC*cw colour bus
  function automatic int col_lsb(input int idx, input int cw);
    return idx * cw;
  endfunction

endpackage

// File: rtl/vga_frame_switch_if.sv
// Source bundle in, selected VGA stream plus switch status out.
interface vga_frame_switch_if #(
  parameter int N_SRC = 2,
  parameter int CW    = 10,
  parameter int FCW   = 8
) ();
  localparam int SW = vga_switch_pkg::sel_width(N_SRC);

  logic [SW-1:0]       req_sel;
  logic [N_SRC*CW-1:0] src_r, src_g, src_b;
  logic [N_SRC-1:0]    src_hs, src_vs, src_blank, src_sync;
  logic [CW-1:0]       vga_r, vga_g, vga_b;
  logic                vga_hs, vga_vs, vga_blank, vga_sync;
  logic [SW-1:0]       active_sel;
  logic                busy, switch_done, sel_err;
  logic [FCW-1:0]      frame_cnt;

  modport master (
    output req_sel, src_r, src_g, src_b, src_hs, src_vs, src_blank, src_sync,
    input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank, vga_sync,
    input  active_sel, busy, switch_done, sel_err, frame_cnt
  );

  modport slave (
    input  req_sel, src_r, src_g, src_b, src_hs, src_vs, src_blank, src_sync,
    output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank, vga_sync,
    output active_sel, busy, switch_done, sel_err, frame_cnt
  );
endinterface

// File: rtl/vga_vs_edge.sv
// Registered vsync falling-edge detector; load overrides the history at a
// source switch so the new source's vsync level does not fake an edge.
module vga_vs_edge (
  input  logic clk,
  input  logic reset,
  input  logic vs_in,
  input  logic load,
  input  logic load_val,
  output logic frame_start
);
  logic vs_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vs_q <= 1'b1;
    else       vs_q <= load ? load_val : vs_in;
  end

  assign frame_start = vs_q & ~vs_in;
endmodule

// File: rtl/vga_frame_switch.sv
// N-source VGA selector that only changes source at a vsync start.
// Build option: VGA_FRAME_SWITCH_BLACKOUT_EN inserts BLACK_FRAMES blank frames.
module vga_frame_switch
  import vga_switch_pkg::*;
#(
  parameter int N_SRC        = 2,
  parameter int CW           = 10,
  parameter int DEFAULT_SEL  = 0,
  parameter int FCW          = 8,
  parameter int BLACK_FRAMES = 2
) (
  input logic              clk,
  input logic              reset,
  vga_frame_switch_if.slave bus
);
  localparam int SW = sel_width(N_SRC);

  if (N_SRC < 2 || N_SRC > 8 || DEFAULT_SEL >= N_SRC ||
      BLACK_FRAMES < 1 || BLACK_FRAMES > 15) begin : g_param_chk
    $error("vga_frame_switch: parameter out of range");
  end

  sw_state_e      state;
  logic [SW-1:0]  active_sel, pend_sel, pend_nxt;
  logic [FCW-1:0] frame_cnt;
  logic           busy, switch_done, sel_err;
  logic           req_bad, frame_start, sw_go, rgb_off;
  int             lsb;

`ifdef VGA_FRAME_SWITCH_BLACKOUT_EN
  logic [3:0] blk_cnt;
  assign rgb_off = (state == BLACK);
`else
  assign rgb_off = 1'b0;
`endif

  // Latest in-range request wins; out-of-range requests leave pend_sel alone
  always_comb begin
    req_bad  = (int'(bus.req_sel) >= N_SRC);
    pend_nxt = pend_sel;
    if (!req_bad) pend_nxt = bus.req_sel;
  end

  assign sw_go = (state == PENDING) && frame_start;

  vga_vs_edge u_vs_edge (
    .clk         (clk),
    .reset       (reset),
    .vs_in       (bus.src_vs[active_sel]),
    .load        (sw_go),
    .load_val    (bus.src_vs[pend_sel]),
    .frame_start (frame_start)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      active_sel  <= SW'(DEFAULT_SEL);
      pend_sel    <= SW'(DEFAULT_SEL);
      frame_cnt   <= '0;
      switch_done <= 1'b0;
      sel_err     <= 1'b0;
      busy        <= 1'b0;
`ifdef VGA_FRAME_SWITCH_BLACKOUT_EN
      blk_cnt     <= '0;
`endif
    end else begin
      switch_done <= 1'b0;
      pend_sel    <= pend_nxt;
      if (req_bad)     sel_err   <= 1'b1;
      if (frame_start) frame_cnt <= frame_cnt + FCW'(1);
      case (state)
        IDLE: begin
          if (pend_nxt != active_sel) begin
            state <= PENDING;
            busy  <= 1'b1;
          end
        end
        PENDING: begin
          // The switch uses the request registered before this cycle
          if (frame_start) begin
            active_sel <= pend_sel;
`ifdef VGA_FRAME_SWITCH_BLACKOUT_EN
            state      <= BLACK;
            blk_cnt    <= 4'(BLACK_FRAMES);
`else
            state       <= IDLE;
            busy        <= 1'b0;
            switch_done <= 1'b1;
`endif
          end else if (pend_nxt == active_sel) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
`ifdef VGA_FRAME_SWITCH_BLACKOUT_EN
        BLACK: begin
          if (frame_start) begin
            if (blk_cnt <= 4'd1) begin
              state       <= IDLE;
              busy        <= 1'b0;
              switch_done <= 1'b1;
            end else begin
              blk_cnt <= blk_cnt - 4'd1;
            end
          end
        end
`endif
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign lsb = col_lsb(int'(active_sel), CW);

  assign bus.vga_r     = rgb_off ? '0 : bus.src_r[lsb +: CW];
  assign bus.vga_g     = rgb_off ? '0 : bus.src_g[lsb +: CW];
  assign bus.vga_b     = rgb_off ? '0 : bus.src_b[lsb +: CW];
  assign bus.vga_hs    = bus.src_hs[active_sel];
  assign bus.vga_vs    = bus.src_vs[active_sel];
  assign bus.vga_blank = bus.src_blank[active_sel];
  assign bus.vga_sync  = bus.src_sync[active_sel];

  assign bus.active_sel  = active_sel;
  assign bus.busy        = busy;
  assign bus.switch_done = switch_done;
  assign bus.frame_cnt   = frame_cnt;
  assign bus.sel_err     = sel_err;
endmodule
